// File: rtl/alu_req_arbiter.sv
// Two-port round-robin front end for a shared add/sub ALU: registers operands, runs one
// evaluation, and holds a tagged, flagged result until the consumer takes it.
module alu_req_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned OP_LEN = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [OP_LEN-1:0] req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [OP_LEN-1:0] req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_cout,
  output logic              rsp_neg,
  output logic              rsp_ovf,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [OP_LEN-1:0] OpAdd    = OP_LEN'(1);
  localparam logic [OP_LEN-1:0] OpNegAdd = OP_LEN'(2);
  localparam logic [OP_LEN-1:0] OpSub    = OP_LEN'(3);
  localparam logic [WIDTH-1:0]  MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic              prio_q;
  logic              id_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [OP_LEN-1:0] op_q;

  logic              rsp_id_q, rsp_cout_q, rsp_neg_q, rsp_ovf_q, rsp_zero_q, rsp_err_q;
  logic [WIDTH-1:0]  rsp_result_q;

  // Arbitration and acceptance
  logic              idle;
  logic              grant_id;
  logic              xfer;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [OP_LEN-1:0] sel_op;
  logic              sel_legal;

  assign idle = (state_q == StIdle);

  // A lone requester always wins; a tie goes to the priority pointer.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = idle && req0_valid && !grant_id;
  assign req1_ready = idle && req1_valid && grant_id;
  assign xfer       = req0_ready || req1_ready;

  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;
  assign sel_op = grant_id ? req1_op : req0_op;

  assign sel_legal = (sel_op == OpAdd) || (sel_op == OpNegAdd) || (sel_op == OpSub);

  // ALU datapath, fed only from the latched operands
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [WIDTH-1:0] add_res, sub_res, neg_res;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;

  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign add_res = add_ext[WIDTH-1:0];
  assign sub_res = sub_ext[WIDTH-1:0];
  assign neg_res = ~add_res + WIDTH'(1);

  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res  = add_res;
        alu_cout = add_ext[WIDTH];
        alu_ovf  = add_ovf;
      end
      OpNegAdd: begin
        // Carry reflects the underlying add; negating the most-negative value overflows.
        alu_res  = neg_res;
        alu_cout = add_ext[WIDTH];
        alu_ovf  = add_ovf || (add_res == MinVal);
      end
      OpSub: begin
        alu_res  = sub_res;
        alu_cout = sub_ext[WIDTH];
        alu_ovf  = sub_ovf;
      end
      default: ;
    endcase
  end

  // Control FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d = sel_legal ? StExec : StResp;
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (xfer) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        op_q   <= sel_op;
        id_q   <= grant_id;
        prio_q <= ~grant_id;
        if (!sel_legal) begin
          rsp_id_q     <= grant_id;
          rsp_result_q <= '0;
          rsp_cout_q   <= 1'b0;
          rsp_neg_q    <= 1'b0;
          rsp_ovf_q    <= 1'b0;
          rsp_zero_q   <= 1'b0;
          rsp_err_q    <= 1'b1;
        end
      end
      if (state_q == StExec) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_res;
        rsp_cout_q   <= alu_cout;
        rsp_neg_q    <= alu_res[WIDTH-1];
        rsp_ovf_q    <= alu_ovf;
        rsp_zero_q   <= (alu_res == '0);
        rsp_err_q    <= 1'b0;
      end
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign busy       = !idle;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_neg    = rsp_neg_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: arithmetic, arbitration order, illegal ops,
// backpressure and mid-operation reset.
module tb_alu_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [4:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [4:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_neg, rsp_ovf, rsp_zero, rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_req_arbiter #(.WIDTH(32), .OP_LEN(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_neg    (rsp_neg),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Flags packed as {cout, neg, ovf, zero, err}
  function automatic logic [4:0] flags();
    return {rsp_cout, rsp_neg, rsp_ovf, rsp_zero, rsp_err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic issue(input string tag, input bit id, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    @(negedge clk);
    check({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Expects a response at N+2 (legal) or N+1 (illegal) and consumes it with rsp_ready=1.
  task automatic expect_rsp(input string tag, input bit legal, input bit id,
                            input logic [31:0] res, input logic [4:0] flg);
    if (legal) begin
      @(negedge clk);
      check({tag, "_early"}, rsp_valid, 1'b0);
    end
    @(negedge clk);
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_result"}, rsp_result, res);
    check({tag, "_flags"}, flags(), flg);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_drop"}, {rsp_valid, busy}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;
    #3;
    check("reset_ctl", {rsp_valid, busy, req0_ready, req1_ready}, 4'b0000);
    check("reset_rsp", {rsp_id, rsp_result, flags()}, '0);
    do_reset();

    // Test 1: 5 + 7
    issue("t1", 1'b0, 32'd5, 32'd7, 5'b00001);
    expect_rsp("t1", 1'b1, 1'b0, 32'd12, 5'b00000);

    // Test 2: subtraction to zero and to -1
    issue("t2a", 1'b1, 32'd3, 32'd3, 5'b00011);
    expect_rsp("t2a", 1'b1, 1'b1, 32'd0, 5'b10010);
    issue("t2b", 1'b1, 32'd0, 32'd1, 5'b00011);
    expect_rsp("t2b", 1'b1, 1'b1, 32'hFFFF_FFFF, 5'b01000);

    // Test 3: simultaneous requests from reset; req0 re-requests and then loses the tie
    do_reset();
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 5'b00001; req0_valid = 1'b1;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = 5'b00010; req1_valid = 1'b1;
    @(negedge clk);
    check("t3_first_grant", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_exec_blocked", {req1_ready, busy}, 2'b01);
    @(negedge clk);
    check("t3_rsp0", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd2});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_second_grant", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("t3_rsp1_early", rsp_valid, 1'b0);
    @(negedge clk);
    check("t3_rsp1", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'hFFFF_FFFE});
    check("t3_rsp1_flags", flags(), 5'b01000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_idle", {busy, rsp_valid, req0_ready}, 3'b000);
    @(posedge clk);
    #1;

    // Test 4: illegal opcode answers one cycle after transfer
    issue("t4", 1'b0, 32'd9, 32'd4, 5'b00111);
    expect_rsp("t4", 1'b0, 1'b0, 32'd0, 5'b00001);

    // Test 5: backpressure holds the response and blocks new requests
    rsp_ready = 1'b0;
    issue("t5", 1'b1, 32'h7FFF_FFFF, 32'd1, 5'b00001);
    req0_a = 32'd2; req0_b = 32'd2; req0_op = 5'b00001; req0_valid = 1'b1;
    @(negedge clk);
    check("t5_early", rsp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d", i), {rsp_valid, rsp_id, rsp_result, flags()},
            {1'b1, 1'b1, 32'h8000_0000, 5'b01100});
      check($sformatf("t5_block%0d", i), {req0_ready, req1_ready}, 2'b00);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_handshake", {rsp_valid, req0_ready}, 2'b10);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t5_release", {rsp_valid, busy, req0_ready}, 3'b001);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;

    // Test 6: reset during EXEC discards the operation and clears prio
    issue("t6", 1'b0, 32'd9, 32'd9, 5'b00001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_ctl", {rsp_valid, busy}, 2'b00);
    check("t6_async_rsp", {rsp_id, rsp_result, flags()}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_quiet%0d", i), {rsp_valid, busy}, 2'b00);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("t6_prio", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
